clock_divider_prog: RTL

Runtime-programmable integer clock divider for the VGA pipeline. It generates a divided square wave `clk_out` and a one-cycle period-start strobe `tick` from the system clock. Downstream timing logic should use `tick` as a clock enable instead of clocking from `clk_out`. The divisor is loaded at runtime and takes effect only at a period boundary, so a mode change never produces a runt period. Default configuration reproduces the fixed divide-by-4 pixel rate (100 MHz → 25 MHz).

---
 rtl/vga_clk_pkg.sv | 12 +
 rtl/clock_divider_prog.sv | 104 ++++++++++
 2 files changed

// File: rtl/vga_clk_pkg.sv
// Shared constants for the VGA pixel-clock generation path: counter width,
// divisors for the supported pixel rates, and the divisor type.
package vga_clk_pkg;

  localparam int DEF_CNT_W = 8;

  localparam int DIV_25MHZ = 4;
  localparam int DIV_50MHZ = 2;

  typedef logic [DEF_CNT_W-1:0] div_t;

endpackage

// File: rtl/clock_divider_prog.sv
// Runtime-programmable integer clock divider: divided square wave plus a
// period-start strobe, with divisor changes deferred to the next period boundary.
module clock_divider_prog
  import vga_clk_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = DIV_25MHZ
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             restart,
  input  logic [CNT_W-1:0] div,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             div_pending,
  output logic             bad_div
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(DEFAULT_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_v_q, pend_v_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             div_pending_q;
  logic             bad_div_q, bad_div_d;

  logic             wrap;
  logic             load_ok;
  logic [CNT_W:0]   high_len;

  assign wrap    = restart | (enable & (cnt_q == (cur_div_q - 1'b1)));
  assign load_ok = div_load & (div != '0);

  always_comb begin
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    pend_v_d   = pend_v_q;
    if (wrap) begin
      cnt_d    = '0;
      pend_v_d = 1'b0;
      if (load_ok) begin
        cur_div_d = div;
      end else if (pend_v_q) begin
        cur_div_d = pend_div_q;
      end
    end else begin
      if (enable) begin
        cnt_d = cnt_q + 1'b1;
      end
      // Last load before the wrap wins.
      if (load_ok) begin
        pend_div_d = div;
        pend_v_d   = 1'b1;
      end
    end
  end

  // Outputs are computed from next-state so they line up with the registered
  // cnt/cur_div of the same cycle.
  always_comb begin
    high_len  = ({1'b0, cur_div_d} + 1'b1) >> 1;
    clk_out_d = ({1'b0, cnt_d} < high_len);
    tick_d    = wrap;
    bad_div_d = div_load & (div == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= RST_CNT;
      cur_div_q     <= RST_DIV;
      pend_v_q      <= 1'b0;
      clk_out_q     <= 1'b0;
      tick_q        <= 1'b0;
      div_pending_q <= 1'b0;
      bad_div_q     <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      cur_div_q     <= cur_div_d;
      pend_v_q      <= pend_v_d;
      clk_out_q     <= clk_out_d;
      tick_q        <= tick_d;
      div_pending_q <= pend_v_d;
      bad_div_q     <= bad_div_d;
    end
  end

  // Pending divisor payload is qualified by pend_v_q, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_div_q <= pend_div_d;
  end

  assign clk_out     = clk_out_q;
  assign tick        = tick_q;
  assign div_pending = div_pending_q;
  assign bad_div     = bad_div_q;

endmodule
